fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 28 ++
 rtl/fetch_credit_ctr.sv | 84 ++++++++
 rtl/fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types for the fetch controller slice:
//   fetch_entry_t      : {pc, instr} pair pushed into the instruction buffer
//   fetch_state_e      : controller FSM states
//   IBUF_DEPTH_DEFAULT : default instruction-buffer depth
//   word_align()       : clears the two byte-offset bits of a PC
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

  localparam int IBUF_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_credit_ctr.sv
// ---------------------------------------------------------------------------
// fetch_credit_ctr
// Tracks instruction-buffer occupancy and outstanding icache requests, and
// derives the credit / in-flight permission flags used to gate new requests.
//   clock, reset     : clock and synchronous active-high reset
//   push_i / pop_i   : buffer push and pop strobes
//   flush_i          : buffer flush, clears occupancy (wins over push/pop)
//   req_hs_i         : icache request handshake
//   rsp_i            : any icache response, kept or dropped
//   occ_o            : current buffer occupancy
//   inflight_o       : current outstanding request count
//   credit_ok_o      : IBUF_DEPTH - occ - inflight is non-zero
//   inflight_ok_o    : inflight is below MAX_INFLIGHT
// ---------------------------------------------------------------------------
module fetch_credit_ctr
  import fetch_ctrl_pkg::*;
#(
  parameter int IBUF_DEPTH   = IBUF_DEPTH_DEFAULT,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic                        req_hs_i,
  input  logic                        rsp_i,
  output logic [$clog2(IBUF_DEPTH):0] occ_o,
  output logic [$clog2(IBUF_DEPTH):0] inflight_o,
  output logic                        credit_ok_o,
  output logic                        inflight_ok_o
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(IBUF_DEPTH);
  localparam logic [CW-1:0] MAX_INF_C = CW'(MAX_INFLIGHT);

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] credits;
  logic          pop_ok;
  logic          rsp_ok;

  always_comb begin
    // Decrements are ignored at zero so a stray pop or a response that
    // belongs to tracking discarded by reset can never wrap a counter.
    pop_ok = pop_i && (occ_q != '0);
    rsp_ok = rsp_i && (inflight_q != '0);

    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (push_i && !pop_ok) begin
      occ_d = occ_q + CW'(1);
    end else if (pop_ok && !push_i) begin
      occ_d = occ_q - CW'(1);
    end

    inflight_d = inflight_q;
    if (req_hs_i && !rsp_ok) begin
      inflight_d = inflight_q + CW'(1);
    end else if (rsp_ok && !req_hs_i) begin
      inflight_d = inflight_q - CW'(1);
    end

    credits = DEPTH_C - occ_q - inflight_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q      <= '0;
      inflight_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  assign occ_o         = occ_q;
  assign inflight_o    = inflight_q;
  assign credit_ok_o   = (credits != '0);
  assign inflight_ok_o = (inflight_q < MAX_INF_C);

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller: issues word-aligned icache requests under a
// credit scheme, tags them with an epoch, pushes matching responses into the
// instruction buffer with zero latency and flushes on redirect.
//   clock, reset            : clock and synchronous active-high reset
//   redirect_i/redirect_pc_i: redirect strobe and new fetch PC
//   icache_req_*            : request valid/addr/epoch out, ready in
//   icache_rsp_*            : in-order response valid/epoch/pc/instr in
//   ibuf_push_o/ibuf_entry_o: buffer push and {pc, instr} entry
//   ibuf_pop_i              : buffer pop (only while non-empty)
//   ibuf_flush_o            : buffer flush, same cycle as redirect
//   stall_cycles_o          : cycles spent in STALL
// Build option: define FETCH_CTRL_STALL_STATS_EN to include the saturating
// stall-cycle counter; otherwise stall_cycles_o is tied to zero.
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          IBUF_DEPTH   = IBUF_DEPTH_DEFAULT,
  parameter int          MAX_INFLIGHT = 4,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_valid_o,
  output logic [31:0] icache_req_addr_o,
  output logic        icache_req_epoch_o,
  input  logic        icache_req_ready_i,
  input  logic        icache_rsp_valid_i,
  input  logic        icache_rsp_epoch_i,
  input  logic [31:0] icache_rsp_pc_i,
  input  logic [31:0] icache_rsp_instr_i,
  output logic        ibuf_push_o,
  output logic [63:0] ibuf_entry_o,
  input  logic        ibuf_pop_i,
  output logic        ibuf_flush_o,
  output logic [31:0] stall_cycles_o
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic          drop_q, drop_d;

  logic          credit_ok;
  logic          inflight_ok;
  logic          req_hs;
  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  fetch_entry_t  entry;

  fetch_credit_ctr #(
    .IBUF_DEPTH   (IBUF_DEPTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clock         (clock),
    .reset         (reset),
    .push_i        (ibuf_push_o),
    .pop_i         (ibuf_pop_i),
    .flush_i       (redirect_i),
    .req_hs_i      (req_hs),
    .rsp_i         (icache_rsp_valid_i),
    .occ_o         (occ),
    .inflight_o    (inflight),
    .credit_ok_o   (credit_ok),
    .inflight_ok_o (inflight_ok)
  );

  // Request / response datapath.
  always_comb begin
    icache_req_valid_o = (state_q == ST_RUN) && credit_ok && inflight_ok && !redirect_i;
    icache_req_addr_o  = pc_q;
    icache_req_epoch_o = epoch_q;
    req_hs             = icache_req_valid_o && icache_req_ready_i;

    // Keep a response only when it carries the live epoch, no redirect is
    // killing this cycle, and the post-reset drop window has closed.
    ibuf_push_o  = icache_rsp_valid_i && !redirect_i && !drop_q &&
                   (icache_rsp_epoch_i == epoch_q);
    ibuf_flush_o = redirect_i;

    entry.pc     = ibuf_push_o ? icache_rsp_pc_i    : 32'h0;
    entry.instr  = ibuf_push_o ? icache_rsp_instr_i : 32'h0;
    ibuf_entry_o = entry;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    drop_d  = drop_q && !req_hs;

    unique case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (!credit_ok || !inflight_ok) state_d = ST_STALL;
      ST_STALL: if (credit_ok && inflight_ok)   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (req_hs) begin
      pc_d = pc_q + 32'd4;
    end

    // Redirect always lands in RUN; the stall check re-evaluates from there.
    if (redirect_i) begin
      state_d = ST_RUN;
      pc_d    = word_align(redirect_pc_i);
      epoch_d = !epoch_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= word_align(RESET_PC);
      epoch_q <= 1'b0;
      drop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      drop_q  <= drop_d;
    end
  end

`ifdef FETCH_CTRL_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = 32'h0;
`endif

  // Credits already reserve a buffer slot for every outstanding request, so
  // these can only fire if the credit accounting itself is broken.
  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(ibuf_push_o && (occ == CW'(IBUF_DEPTH))));
  a_inflight_bounded: assert property (@(posedge clock) disable iff (reset)
    (inflight <= CW'(MAX_INFLIGHT)));

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int          D   = 16;
  localparam int          MI  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        icache_req_valid_o;
  logic [31:0] icache_req_addr_o;
  logic        icache_req_epoch_o;
  logic        icache_req_ready_i;
  logic        icache_rsp_valid_i;
  logic        icache_rsp_epoch_i;
  logic [31:0] icache_rsp_pc_i;
  logic [31:0] icache_rsp_instr_i;
  logic        ibuf_push_o;
  logic [63:0] ibuf_entry_o;
  logic        ibuf_pop_i;
  logic        ibuf_flush_o;
  logic [31:0] stall_cycles_o;

  always #5 clock = ~clock;

  fetch_ctrl #(.IBUF_DEPTH(D), .MAX_INFLIGHT(MI), .RESET_PC(RPC)) dut (
    .clock              (clock),
    .reset              (reset),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .icache_req_valid_o (icache_req_valid_o),
    .icache_req_addr_o  (icache_req_addr_o),
    .icache_req_epoch_o (icache_req_epoch_o),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_rsp_valid_i (icache_rsp_valid_i),
    .icache_rsp_epoch_i (icache_rsp_epoch_i),
    .icache_rsp_pc_i    (icache_rsp_pc_i),
    .icache_rsp_instr_i (icache_rsp_instr_i),
    .ibuf_push_o        (ibuf_push_o),
    .ibuf_entry_o       (ibuf_entry_o),
    .ibuf_pop_i         (ibuf_pop_i),
    .ibuf_flush_o       (ibuf_flush_o),
    .stall_cycles_o     (stall_cycles_o)
  );

  // Behavioural icache: accepted requests wait in order until their due cycle.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ep;
    int          due;
  } icq_t;
  icq_t icq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 2;

  // Stimulus knobs.
  logic        k_reset = 1'b0, k_pop = 1'b0, k_redirect = 1'b0, k_ready = 1'b0, k_rsp_en = 1'b0;
  logic [31:0] k_rpc = 32'h0;

  // Reference model: mode 0 idle, 1 run, 2 stall.
  int          m_state = 0, m_occ = 0, m_inf = 0;
  logic [31:0] m_pc = RPC, m_stall = 32'h0;
  logic        m_ep = 1'b0, m_drop = 1'b1;

  // Per-cycle snapshots.
  logic [147:0] obs_v, exp_v;
  logic         cmp_en;
  logic         o_hs, o_push, o_flush, o_rv, o_valid, o_pop;
  logic [31:0]  o_addr, o_push_pc, o_stall;
  int           o_occ;

  task automatic step();
    logic        rv, rep, popd, ev, ep_push, mhs, rdec;
    logic [31:0] rpc, rin;
    int          cred;
    icq_t        r;
    @(negedge clock);
    reset              = k_reset;
    redirect_i         = k_redirect;
    redirect_pc_i      = k_rpc;
    icache_req_ready_i = k_ready;
    popd               = k_pop && (m_occ > 0) && !k_reset;
    ibuf_pop_i         = popd;
    rv  = k_rsp_en && (icq.size() > 0) && (icq.size() > 0 ? icq[0].due <= cyc : 1'b0);
    rpc = rv ? icq[0].pc : 32'h0;
    rin = rv ? icq[0].instr : 32'h0;
    rep = rv ? icq[0].ep : 1'b0;
    icache_rsp_valid_i = rv;
    icache_rsp_pc_i    = rpc;
    icache_rsp_instr_i = rin;
    icache_rsp_epoch_i = rep;
    #1;
    cred    = D - m_occ - m_inf;
    ev      = (m_state == 1) && (cred > 0) && (m_inf < MI) && !k_redirect;
    ep_push = rv && !k_redirect && !m_drop && (rep == m_ep);
    exp_v = {ev, (ev ? m_pc : 32'h0), (ev ? m_ep : 1'b0), ep_push,
             (ep_push ? {rpc, rin} : 64'h0), k_redirect, m_stall, 8'(m_occ), 8'(m_inf)};
    obs_v = {icache_req_valid_o, (icache_req_valid_o ? icache_req_addr_o : 32'h0),
             (icache_req_valid_o ? icache_req_epoch_o : 1'b0), ibuf_push_o,
             (ibuf_push_o ? ibuf_entry_o : 64'h0), ibuf_flush_o, stall_cycles_o,
             8'(dut.u_credit.occ_o), 8'(dut.u_credit.inflight_o)};
    cmp_en    = !k_reset;
    o_valid   = icache_req_valid_o;
    o_hs      = icache_req_valid_o && k_ready && !k_reset;
    o_addr    = icache_req_addr_o;
    o_push    = ibuf_push_o && !k_reset;
    o_push_pc = ibuf_entry_o[63:32];
    o_flush   = ibuf_flush_o;
    o_rv      = rv;
    o_pop     = popd;
    o_stall   = stall_cycles_o;
    o_occ     = int'(dut.u_credit.occ_o);
    @(posedge clock);
    if (rv) void'(icq.pop_front());
    if (o_hs) begin
      r.pc = icache_req_addr_o; r.instr = $urandom; r.ep = icache_req_epoch_o; r.due = cyc + lat;
      icq.push_back(r);
    end
    if (k_reset) begin
      m_state = 0; m_pc = RPC; m_ep = 1'b0; m_occ = 0; m_inf = 0; m_drop = 1'b1; m_stall = 32'h0;
    end else begin
      mhs  = ev && k_ready;
      rdec = rv && (m_inf > 0);
`ifdef FETCH_CTRL_STALL_STATS_EN
      if (m_state == 2 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      if (k_redirect) begin
        m_state = 1; m_pc = k_rpc & 32'hFFFF_FFFC; m_ep = ~m_ep; m_occ = 0;
      end else begin
        case (m_state)
          0: m_state = 1;
          1: if (cred == 0 || m_inf == MI) m_state = 2;
          default: if (cred > 0 && m_inf < MI) m_state = 1;
        endcase
        m_occ = m_occ + int'(ep_push) - int'(popd);
        if (mhs) m_pc = m_pc + 32'd4;
      end
      m_inf = m_inf + int'(mhs) - int'(rdec);
      if (mhs) m_drop = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset(input bit keep_q);
    if (!keep_q) icq.delete();
    k_reset = 1'b1; k_pop = 1'b0; k_redirect = 1'b0; k_ready = 1'b0; k_rsp_en = 1'b0;
    step();
    step();
    k_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(0);
    step();
    checks++;
    if (obs_v !== 148'h0) begin
      failures++; $display("FAIL reset_state got=%h required=0", obs_v);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_addr !== RPC) begin
      failures++; $display("FAIL run_after_idle valid=%b addr=%h required valid=1 addr=%h", o_valid, o_addr, RPC);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_first_requests();
    logic [31:0] addrs[$];
    k_ready = 1'b1; k_rsp_en = 1'b1; lat = 2;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL first_req_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_hs) addrs.push_back(o_addr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addrs.size() || addrs[i] !== RPC + 32'(4 * i)) begin
        failures++; $display("FAIL first_req_addr idx=%0d got=%h required=%h", i, (i < addrs.size()) ? addrs[i] : 32'hX, RPC + 32'(4 * i));
      end
    end
    $display("test_first_requests done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_inflight_cap();
    int n_hs = 0;
    bit seen_rsp = 0, got = 0;
    do_reset(0);
    k_ready = 1'b1; k_rsp_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL cap_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_hs) n_hs++;
    end
    checks++;
    if (n_hs != MI) begin failures++; $display("FAIL inflight_cap requests=%0d required=%0d", n_hs, MI); end
    k_rsp_en = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL cap_release_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_hs) begin
        got = 1;
        checks++;
        if (!seen_rsp || o_addr !== RPC + 32'h10) begin
          failures++; $display("FAIL cap_release addr=%h after_rsp=%0d required addr=%h after_rsp=1", o_addr, seen_rsp, RPC + 32'h10);
        end
      end
      if (o_rv) seen_rsp = 1;
    end
    if (!got) begin checks++; failures++; $display("FAIL cap_release_timeout got=none required=request"); end
    $display("test_inflight_cap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fill_stall();
    int n_hs = 0, n_push = 0;
    do_reset(0);
    k_ready = 1'b1; k_rsp_en = 1'b1; lat = 2;
    for (int i = 0; i < 80; i++) begin
      step();
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL fill_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_hs) n_hs++;
      if (o_push) n_push++;
    end
    checks++;
    if (n_push != D || n_hs != D || o_occ != D) begin
      failures++; $display("FAIL fill_count pushes=%0d reqs=%0d occ=%0d required %0d each", n_push, n_hs, o_occ, D);
    end
    checks++;
`ifdef FETCH_CTRL_STALL_STATS_EN
    if (o_stall == 32'h0) begin failures++; $display("FAIL stall_stat got=%0d required=nonzero", o_stall); end
`else
    if (o_stall !== 32'h0) begin failures++; $display("FAIL stall_stat got=%0d required=0", o_stall); end
`endif
    $display("test_fill_stall done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_pop_resume();
    int n_hs = 0, n_push = 0;
    k_pop = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      k_pop = 1'b0;
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL pop_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_hs) n_hs++;
      if (o_push) n_push++;
    end
    checks++;
    if (n_hs != 1 || n_push != 1 || o_occ != D) begin
      failures++; $display("FAIL pop_resume reqs=%0d pushes=%0d occ=%0d required 1 1 %0d", n_hs, n_push, o_occ, D);
    end
    $display("test_pop_resume done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_redirect();
    int n_hs = 0, n_flush = 0, n_drop = 0;
    bit got = 0;
    logic [31:0] first_pc = 32'h0;
    do_reset(0);
    k_ready = 1'b1; k_rsp_en = 1'b0;
    for (int i = 0; i < 10 && n_hs < 3; i++) begin
      step();
      if (o_hs) n_hs++;
    end
    checks++;
    if (n_hs != 3) begin failures++; $display("FAIL redirect_setup reqs=%0d required=3", n_hs); end
    k_ready = 1'b0;
    k_redirect = 1'b1; k_rpc = 32'h100;
    for (int i = 0; i < 30; i++) begin
      step();
      k_redirect = 1'b0; k_ready = 1'b1; k_rsp_en = 1'b1;
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL redirect_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_flush) n_flush++;
      if (o_rv && !o_push) n_drop++;
      if (o_push && !got) begin got = 1; first_pc = o_push_pc; end
    end
    checks++;
    if (n_flush != 1 || n_drop != 3 || !got || first_pc !== 32'h100) begin
      failures++; $display("FAIL redirect flushes=%0d drops=%0d first_pc=%h required 1 3 00000100", n_flush, n_drop, first_pc);
    end
    $display("test_redirect done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_same_cycle();
    bit found = 0;
    do_reset(0);
    k_ready = 1'b1; k_rsp_en = 1'b1; lat = 2;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_occ == 8 && icq.size() > 0 && icq[0].due <= cyc) found = 1;
      else step();
    end
    if (!found) begin checks++; failures++; $display("FAIL same_cycle_setup_timeout occ=%0d required=8", m_occ); end
    k_pop = 1'b1;
    step();
    checks++;
    if (!(o_push && o_pop) || obs_v !== exp_v) begin
      failures++; $display("FAIL push_pop_cycle push=%b pop=%b got=%h required=%h", o_push, o_pop, obs_v, exp_v);
    end
    k_pop = 1'b0; k_ready = 1'b0; k_rsp_en = 1'b0;
    step();
    checks++;
    if (o_occ != 8) begin failures++; $display("FAIL occ_push_pop got=%0d required=8", o_occ); end
    k_rsp_en = 1'b1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (icq.size() > 0 && icq[0].due <= cyc) found = 1;
      else step();
    end
    if (!found) begin checks++; failures++; $display("FAIL same_cycle_rsp_timeout got=none required=response"); end
    k_redirect = 1'b1; k_pop = 1'b1; k_rpc = 32'h200;
    step();
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL redirect_push_pop got=%h required=%h", obs_v, exp_v); end
    k_redirect = 1'b0; k_pop = 1'b0; k_rsp_en = 1'b0;
    step();
    checks++;
    if (o_occ != 0) begin failures++; $display("FAIL occ_after_redirect got=%0d required=0", o_occ); end
    $display("test_same_cycle done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_burst();
    int n_push = 0;
    bit got = 0;
    do_reset(0);
    k_ready = 1'b1; k_rsp_en = 1'b1; lat = 3;
    for (int i = 0; i < 8; i++) step();
    k_ready = 1'b0; k_reset = 1'b1;
    step();
    k_reset = 1'b0;
    for (int i = 0; i < 12 && icq.size() > 0; i++) begin
      step();
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL mid_reset_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
      if (o_push) n_push++;
    end
    checks++;
    if (n_push != 0 || icq.size() != 0) begin
      failures++; $display("FAIL stale_after_reset pushes=%0d pending=%0d required 0 0", n_push, icq.size());
    end
    k_ready = 1'b1;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (o_hs) begin
        got = 1;
        checks++;
        if (o_addr !== RPC) begin failures++; $display("FAIL first_req_after_reset got=%h required=%h", o_addr, RPC); end
      end
    end
    if (!got) begin checks++; failures++; $display("FAIL first_req_after_reset_timeout got=none required=request"); end
    $display("test_reset_mid_burst done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    do_reset(0);
    for (int i = 0; i < 1500; i++) begin
      k_pop      = ($urandom_range(0, 1) == 1);
      k_ready    = ($urandom_range(0, 3) != 0);
      k_rsp_en   = ($urandom_range(0, 9) < 7);
      k_redirect = ($urandom_range(0, 32) == 0);
      k_rpc      = $urandom;
      lat        = $urandom_range(1, 4);
      step();
      if (cmp_en) begin
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL random_cycle cyc=%0d got=%h required=%h", cyc, obs_v, exp_v); end
      end
    end
    k_redirect = 1'b0; k_pop = 1'b0;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; icache_req_ready_i = 1'b0;
    icache_rsp_valid_i = 1'b0; icache_rsp_epoch_i = 1'b0; icache_rsp_pc_i = 32'h0;
    icache_rsp_instr_i = 32'h0; ibuf_pop_i = 1'b0;
    test_reset();
    test_first_requests();
    test_inflight_cap();
    test_fill_stall();
    test_pop_resume();
    test_redirect();
    test_same_cycle();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
